// File: rtl/video_tpg_pkg.sv
// video_tpg_pkg: shared controller state encoding and default geometry.
//   DIMW_DEF    width of the TPG size-adjust fields
//   BASE_H_DEF  unadjusted frame height in lines
//   BASE_W_DEF  unadjusted line width in pixels
//   state_t     run-control states of video_tpg_ctrl
package video_tpg_pkg;
    localparam int DIMW_DEF   = 13;
    localparam int BASE_H_DEF = 1080;
    localparam int BASE_W_DEF = 1920;
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
endpackage

// File: rtl/tpg_frame_tracker.sv
// tpg_frame_tracker: follows the TPG AXIS output and flags the end of each frame.
//   clk, rstn                  clock, async active-low reset
//   mon_tvalid/tready/tuser/tlast  tap of the TPG stream; a beat is valid&&ready
//   subh, addh                 currently applied height adjusts
//   eof                        combinational, high on the tlast beat of the last line
module tpg_frame_tracker
    import video_tpg_pkg::*;
#(
    parameter int DIMW   = DIMW_DEF,
    parameter int BASE_H = BASE_H_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            mon_tvalid,
    input  logic            mon_tready,
    input  logic            mon_tuser,
    input  logic            mon_tlast,
    input  logic [DIMW-1:0] subh,
    input  logic [DIMW-1:0] addh,
    output logic            eof
);
    localparam logic signed [DIMW+1:0] BH = (DIMW+2)'(BASE_H);
    logic signed [DIMW+1:0] eff_h, last_line;
    logic [DIMW+1:0] line_cnt, cur;
    logic beat, synced;
    assign eff_h     = BH - $signed({2'b00, subh}) + $signed({2'b00, addh});
    assign last_line = eff_h - 1;
    assign beat      = mon_tvalid & mon_tready;
    // A tuser beat restarts the count in the same cycle it arrives.
    assign cur       = mon_tuser ? '0 : line_cnt;
    // Until a tuser beat has been seen the line count is meaningless, so no eof.
    assign eof       = beat & mon_tlast & (synced | mon_tuser) & ($signed(cur) == last_line);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_cnt <= '0;
            synced   <= 1'b0;
        end else if (beat) begin
            line_cnt <= mon_tlast ? cur + 1'b1 : cur;
            synced   <= synced | mon_tuser;
        end
    end
endmodule

// File: rtl/video_tpg_ctrl.sv
// video_tpg_ctrl: run/stop sequencing and frame-aligned size updates for a TPG.
//   start, stop, num_frames      run request, graceful stop, frames per run (0 = forever)
//   cfg_valid/cfg_ready, cfg_*   size-adjust update handshake
//   mon_*                        tap of the TPG AXIS output
//   tpg_en, tpg_*                TPG enable and applied adjusts
//   busy, done, cfg_err, frame_cnt  status; done and cfg_err are one-cycle pulses
module video_tpg_ctrl
    import video_tpg_pkg::*;
#(
    parameter int DIMW   = DIMW_DEF,
    parameter int BASE_H = BASE_H_DEF,
    parameter int BASE_W = BASE_W_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            stop,
    input  logic [15:0]     num_frames,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [DIMW-1:0] cfg_subh,
    input  logic [DIMW-1:0] cfg_addh,
    input  logic [DIMW-1:0] cfg_subw,
    input  logic [DIMW-1:0] cfg_addw,
    input  logic            mon_tvalid,
    input  logic            mon_tready,
    input  logic            mon_tuser,
    input  logic            mon_tlast,
    output logic            tpg_en,
    output logic [DIMW-1:0] tpg_subh,
    output logic [DIMW-1:0] tpg_addh,
    output logic [DIMW-1:0] tpg_subw,
    output logic [DIMW-1:0] tpg_addw,
    output logic            busy,
    output logic            done,
    output logic            cfg_err,
    output logic [15:0]     frame_cnt
);
    localparam logic signed [DIMW+1:0] BH  = (DIMW+2)'(BASE_H);
    localparam logic signed [DIMW+1:0] BW  = (DIMW+2)'(BASE_W);
    localparam logic signed [DIMW+1:0] ONE = 1;
    state_t state, state_nx;
    logic signed [DIMW+1:0] req_h, req_w;
    logic [4*DIMW-1:0] pend;
    logic pend_v, eof, cfg_fire, cfg_bad, last, go_idle;
    tpg_frame_tracker #(.DIMW(DIMW), .BASE_H(BASE_H)) u_trk (
        .clk(clk), .rstn(rstn),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
        .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
        .subh(tpg_subh), .addh(tpg_addh), .eof(eof)
    );
    assign req_h     = BH - $signed({2'b00, cfg_subh}) + $signed({2'b00, cfg_addh});
    assign req_w     = BW - $signed({2'b00, cfg_subw}) + $signed({2'b00, cfg_addw});
    assign cfg_bad   = (req_h < ONE) || (req_w < ONE);
    assign cfg_ready = !pend_v;
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign busy      = state != IDLE;
    assign tpg_en    = busy;
    assign last      = (num_frames != 16'd0) && ({1'b0, frame_cnt} + 17'd1 == {1'b0, num_frames});
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        go_idle  = 1'b0;
        unique case (state)
            IDLE:     if (start && !stop) state_nx = RUN;
            RUN:      if (eof && last) begin
                          state_nx = IDLE;
                          go_idle  = 1'b1;
                      end else if (stop) state_nx = STOPPING;
            STOPPING: if (eof) begin
                          state_nx = IDLE;
                          go_idle  = 1'b1;
                      end
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            pend_v    <= 1'b0;
            pend      <= '0;
            {tpg_subh, tpg_addh, tpg_subw, tpg_addw} <= '0;
        end else begin
            done    <= go_idle;
            cfg_err <= cfg_fire & cfg_bad;
            if (state == IDLE && state_nx == RUN) frame_cnt <= '0;
            else if (eof && busy && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            // Pending updates land the cycle after eof so the eof that closes the
            // frame was judged on the old height; a stray pending in IDLE is flushed.
            if (pend_v && (eof || !busy)) begin
                {tpg_subh, tpg_addh, tpg_subw, tpg_addw} <= pend;
                pend_v <= 1'b0;
            end else if (cfg_fire && !cfg_bad) begin
                if (busy) begin
                    pend   <= {cfg_subh, cfg_addh, cfg_subw, cfg_addw};
                    pend_v <= 1'b1;
                end else begin
                    {tpg_subh, tpg_addh, tpg_subw, tpg_addw} <= {cfg_subh, cfg_addh, cfg_subw, cfg_addw};
                end
            end
        end
    end
endmodule

// File: tb/tb_video_tpg_ctrl.sv
// tb_video_tpg_ctrl: scoreboard bench emulating a TPG stream against a run-level model.
module tb_video_tpg_ctrl;
    localparam int DIMW = 13;
    localparam int BH   = 4;
    localparam int BW   = 8;
    typedef logic [4*DIMW-1:0] pack_t;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, stop = 1'b0;
    logic [15:0] num_frames = '0;
    logic cfg_valid = 1'b0, cfg_ready;
    logic [DIMW-1:0] cfg_subh = '0, cfg_addh = '0, cfg_subw = '0, cfg_addw = '0;
    logic mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tuser = 1'b0, mon_tlast = 1'b0;
    logic tpg_en, busy, done, cfg_err;
    logic [DIMW-1:0] tpg_subh, tpg_addh, tpg_subw, tpg_addw;
    logic [15:0] frame_cnt;
    logic [31:0] cyc = '0;
    pack_t tp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tp = {tpg_subh, tpg_addh, tpg_subw, tpg_addw};

    video_tpg_ctrl #(.DIMW(DIMW), .BASE_H(BH), .BASE_W(BW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .num_frames(num_frames),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_subh(cfg_subh), .cfg_addh(cfg_addh), .cfg_subw(cfg_subw), .cfg_addw(cfg_addw),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
        .tpg_en(tpg_en), .tpg_subh(tpg_subh), .tpg_addh(tpg_addh), .tpg_subw(tpg_subw), .tpg_addw(tpg_addw),
        .busy(busy), .done(done), .cfg_err(cfg_err), .frame_cnt(frame_cnt)
    );

    int n_cmp = 0, n_bad = 0;
    int q_fc[$], q_done[$];
    pack_t q_cerr[$], q_tpg[$];

    // Reference model: run state (0 idle, 1 running, 2 stopping), frame counter,
    // applied and pending adjusts, and the emulated TPG's position in the frame.
    int m_state = 0, m_fc = 0, m_nf = 0, m_line = 0, mode = 0;
    bit m_sync = 0, m_pend = 0;
    int m_cfg[4] = '{0, 0, 0, 0};
    int m_pcfg[4] = '{0, 0, 0, 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic pack_t pk(input int c[4]);
        return {DIMW'(c[0]), DIMW'(c[1]), DIMW'(c[2]), DIMW'(c[3])};
    endfunction
    function automatic int m_h();
        return BH - m_cfg[0] + m_cfg[1];
    endfunction
    function automatic int m_w();
        return BW - m_cfg[2] + m_cfg[3];
    endfunction

    task automatic m_eof();
        if (m_state == 0) return;
        if (m_fc < 65535) m_fc++;
        q_fc.push_back(m_fc);
        if (m_pend) begin
            if (pk(m_pcfg) != pk(m_cfg)) q_tpg.push_back(pk(m_pcfg));
            m_cfg  = m_pcfg;
            m_pend = 0;
        end
        if (m_state == 2 || (m_nf != 0 && m_fc == m_nf)) begin
            m_state = 0;
            q_done.push_back(m_fc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit u, input bit l);
        bit got, v, r;
        got = 0;
        while (!got) begin
            case (mode)
                0:       begin v = 1; r = 1; end
                1:       begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 2) != 0); end
                default: begin v = 1; r = cyc[1]; end
            endcase
            mon_tvalid = v; mon_tready = r; mon_tuser = u; mon_tlast = l;
            @(posedge clk);
            #1;
            got = v && r;
        end
        mon_tvalid = 0; mon_tready = 0; mon_tuser = 0; mon_tlast = 0;
        if (u) begin m_line = 0; m_sync = 1; end
        if (l) begin
            if (m_sync && m_line == m_h() - 1) m_eof();
            m_line++;
        end
    endtask

    task automatic set_nf(input int n);
        num_frames = 16'(n);
        m_nf = n;
    endtask

    task automatic pulse_start();
        start = 1;
        idle(1);
        start = 0;
        if (m_state == 0) begin
            m_state = 1;
            if (m_fc != 0) q_fc.push_back(0);
            m_fc = 0;
        end
        chk("tpg_en_on", tpg_en, m_state != 0);
    endtask

    task automatic pulse_stop();
        stop = 1;
        idle(1);
        stop = 0;
        if (m_state == 1) m_state = 2;
        chk("busy_after_stop", busy, m_state != 0);
    endtask

    task automatic do_cfg(input int sh, input int ah, input int sw, input int aw);
        int c[4];
        chk("cfg_ready", cfg_ready, !m_pend);
        if (m_pend) return;
        cfg_valid = 1;
        cfg_subh = DIMW'(sh); cfg_addh = DIMW'(ah); cfg_subw = DIMW'(sw); cfg_addw = DIMW'(aw);
        idle(1);
        cfg_valid = 0;
        c = '{sh, ah, sw, aw};
        if (BH - sh + ah < 1 || BW - sw + aw < 1) q_cerr.push_back(pk(m_cfg));
        else if (m_state == 0) begin
            if (pk(c) != pk(m_cfg)) q_tpg.push_back(pk(c));
            m_cfg = c;
        end else begin
            m_pcfg = c;
            m_pend = 1;
        end
        chk("cfg_ready_after", cfg_ready, !m_pend);
    endtask

    // One frame as an honest TPG would emit it with the adjusts in force at its start.
    task automatic frame(input int stop_at, input int cfg_at, input int n_max,
                         input int sh, input int ah, input int sw, input int aw);
        int h, w, k;
        h = m_h(); w = m_w(); k = 0;
        for (int l = 0; l < h; l++)
            for (int p = 0; p < w; p++) begin
                if (k == n_max) return;
                if (k == stop_at) pulse_stop();
                if (k == cfg_at) do_cfg(sh, ah, sw, aw);
                beat(k == 0, p == w - 1);
                k++;
            end
    endtask

    task automatic do_reset();
        rstn = 0; start = 0; stop = 0; cfg_valid = 0; mon_tvalid = 0;
        idle(2);
        chk("rst_tpg_en", tpg_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_tpg_adj", tp, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_queues_drained", q_fc.size() + q_done.size() + q_cerr.size() + q_tpg.size(), 0);
        q_fc.delete(); q_done.delete(); q_cerr.delete(); q_tpg.delete();
        m_state = 0; m_fc = 0; m_line = 0; m_sync = 0; m_pend = 0;
        m_cfg = '{0, 0, 0, 0};
        rstn = 1;
        idle(1);
    endtask

    // Monitor: every visible DUT event consumes the oldest matching expectation.
    initial begin
        logic [15:0] p_fc;
        pack_t p_tp;
        p_fc = '0; p_tp = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                p_fc = frame_cnt;
                p_tp = tp;
            end else begin
                if (frame_cnt !== p_fc) begin
                    if (q_fc.size() == 0) chk("frame_cnt_unexpected", frame_cnt, p_fc);
                    else chk("frame_cnt", frame_cnt, q_fc.pop_front());
                    p_fc = frame_cnt;
                end
                if (done) begin
                    if (q_done.size() == 0) chk("done_unexpected", done, 0);
                    else begin
                        chk("done_frame_cnt", frame_cnt, q_done.pop_front());
                        chk("done_busy", busy, 0);
                        chk("done_tpg_en", tpg_en, 0);
                    end
                end
                if (cfg_err) begin
                    if (q_cerr.size() == 0) chk("cfg_err_unexpected", cfg_err, 0);
                    else chk("cfg_err_tpg_adj", tp, q_cerr.pop_front());
                end
                if (tp !== p_tp) begin
                    if (q_tpg.size() == 0) chk("tpg_adj_unexpected", tp, p_tp);
                    else chk("tpg_adj", tp, q_tpg.pop_front());
                    p_tp = tp;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, nfr, tot, sa, ca;
        do_reset();
        // Two-frame run.
        set_nf(2); mode = 0;
        pulse_start();
        frame(-1, -1, -1, 0, 0, 0, 0);
        frame(-1, -1, -1, 0, 0, 0, 0);
        idle(3);
        chk("A_tpg_en", tpg_en, m_state != 0);
        chk("A_frame_cnt", frame_cnt, m_fc);
        // Continuous run stopped mid second line of frame 2.
        set_nf(0);
        pulse_start();
        frame(-1, -1, -1, 0, 0, 0, 0);
        frame(BW + 3, -1, -1, 0, 0, 0, 0);
        idle(3);
        // Height change while running lands after the current frame.
        pulse_start();
        frame(-1, 5, -1, 1, 0, 0, 0);
        chk("C_tpg_subh", tpg_subh, m_cfg[0]);
        frame(-1, -1, -1, 0, 0, 0, 0);
        frame(2, -1, -1, 0, 0, 0, 0);
        idle(3);
        // Rejected and accepted updates while idle.
        do_cfg(4, 0, 0, 0);
        idle(2);
        do_cfg(0, 0, 9, 0);
        idle(2);
        do_cfg(0, 0, 0, 0);
        idle(2);
        // Ready toggling every two cycles.
        mode = 2; set_nf(2);
        pulse_start();
        frame(-1, -1, -1, 0, 0, 0, 0);
        frame(-1, -1, -1, 0, 0, 0, 0);
        idle(3);
        // Randomized runs.
        for (int it = 0; it < 10; it++) begin
            mode = $urandom_range(0, 2);
            nf = $urandom_range(0, 3);
            set_nf(nf);
            pulse_start();
            nfr = (nf == 0) ? $urandom_range(1, 3) : nf;
            for (int i = 0; i < nfr; i++) begin
                tot = m_h() * m_w();
                sa = (nf == 0 && i == nfr - 1) ? $urandom_range(0, tot - 1) : -1;
                ca = ($urandom_range(0, 1) != 0) ? $urandom_range(0, tot - 1) : -1;
                frame(sa, ca, -1, $urandom_range(0, 5), $urandom_range(0, 2),
                      $urandom_range(0, 9), $urandom_range(0, 2));
            end
            idle(3);
            if ($urandom_range(0, 1) != 0)
                do_cfg($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 9), $urandom_range(0, 2));
            idle(2);
        end
        // Reset on line 2 of a frame, then resume mid-frame without tuser.
        mode = 0; set_nf(0);
        pulse_start();
        frame(-1, -1, m_w() + 3, 0, 0, 0, 0);
        do_reset();
        pulse_start();
        for (int l = 0; l < 4; l++)
            for (int p = 0; p < m_w(); p++) beat(0, p == m_w() - 1);
        chk("G_no_eof_before_tuser", frame_cnt, m_fc);
        frame(-1, -1, -1, 0, 0, 0, 0);
        frame(0, -1, -1, 0, 0, 0, 0);
        idle(10);
        chk("end_q_frame_cnt", q_fc.size(), 0);
        chk("end_q_done", q_done.size(), 0);
        chk("end_q_cfg_err", q_cerr.size(), 0);
        chk("end_q_tpg_adj", q_tpg.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
